// File: rtl/wisc_pkg.sv
// ============================================================================
// Module   : wisc_pkg
// Brief    : Shared datapath widths, branch-type and EX/MEM FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package wisc_pkg;
   localparam int WISC_WIDTH = 16;
   localparam int WISC_REGW  = 3;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQZ = 3'd1,
      BR_BNEZ = 3'd2,
      BR_BLTZ = 3'd3,
      BR_BGEZ = 3'd4,
      BR_JUMP = 3'd5
   } br_type_e;

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;
endpackage

`default_nettype wire

// File: rtl/br_resolve.sv
// ============================================================================
// Module   : br_resolve
// Brief    : Combinational branch/jump taken decision from ALU Z/N flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_resolve
   import wisc_pkg::*;
(
   input  logic [2:0] br_type,
   input  logic       z,
   input  logic       n,
   input  logic       valid,
   output logic       taken
);
   logic w_cond;

   always_comb begin
      w_cond = 1'b0;
      case (br_type)
         BR_BEQZ: w_cond = z;
         BR_BNEZ: w_cond = ~z;
         BR_BLTZ: w_cond = n;
         BR_BGEZ: w_cond = ~n;
         BR_JUMP: w_cond = 1'b1;
         default: w_cond = 1'b0;
      endcase
   end

   assign taken = valid & w_cond;
endmodule

`default_nettype wire

// File: rtl/dff.sv
// ============================================================================
// Module   : dff
// Brief    : Basic W-bit D flip-flop with synchronous active-high reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst) q <= '0;
      else     q <= d;
   end
endmodule

`default_nettype wire

// File: rtl/dff_en.sv
// ============================================================================
// Module   : dff_en
// Brief    : dff cell wrapped with a load-enable recirculation mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] w_d;

   assign w_d = en ? d : q;

   dff #(.W(W)) u_dff (
      .clk (clk),
      .rst (rst),
      .d   (w_d),
      .q   (q)
   );
endmodule

`default_nettype wire

// File: rtl/ex_mem_latch.sv
// ============================================================================
// Module   : ex_mem_latch
// Brief    : EX/MEM pipeline register with branch resolution, one-cycle fetch
//            redirect, halt FSM and bubble insertion.
//            Optional overflow trap enabled by macro EX_MEM_OFL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_latch
   import wisc_pkg::*;
#(
   parameter int WIDTH = WISC_WIDTH,
   parameter int REGW  = WISC_REGW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [WIDTH-1:0] ex_alu_out,
   input  logic             ex_alu_z,
   input  logic             ex_alu_n,
   input  logic             ex_alu_ofl,
   input  logic [2:0]       ex_br_type,
   input  logic [WIDTH-1:0] ex_br_target,
   input  logic [WIDTH-1:0] ex_pc_inc,
   input  logic [REGW-1:0]  ex_rd,
   input  logic             ex_reg_wr,
   input  logic             ex_mem_rd,
   input  logic             ex_mem_wr,
   input  logic [WIDTH-1:0] ex_st_data,
   input  logic             ex_halt,
   input  logic             ex_arith,
   input  logic             stall,
   input  logic             flush,
   output logic             mem_valid,
   output logic [WIDTH-1:0] mem_alu_out,
   output logic [WIDTH-1:0] mem_pc_inc,
   output logic [REGW-1:0]  mem_rd,
   output logic             mem_reg_wr,
   output logic             mem_mem_rd,
   output logic             mem_mem_wr,
   output logic [WIDTH-1:0] mem_st_data,
   output logic             mem_redirect,
   output logic [WIDTH-1:0] mem_redirect_pc,
   output logic             mem_halted,
   output logic             mem_ofl_exc
);
   localparam int C_DATA_W = 4*WIDTH + REGW;

   logic             w_taken;
   logic             w_trap;
   logic             w_halt_go;
   logic             w_load;
   logic             w_bubble;
   logic             w_halted;
   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [4:0]       w_ctrl_d;
   logic [4:0]       r_ctrl;
   logic [C_DATA_W-1:0] w_data_d;
   logic [C_DATA_W-1:0] r_data;

   br_resolve u_br_resolve (
      .br_type (ex_br_type),
      .z       (ex_alu_z),
      .n       (ex_alu_n),
      .valid   (ex_valid),
      .taken   (w_taken)
   );

`ifdef EX_MEM_OFL_TRAP_EN
   logic r_ofl_exc;

   assign w_trap = ex_valid & ex_arith & ex_alu_ofl;

   dff_en #(.W(1)) u_ofl_exc (
      .clk (clk),
      .rst (rst),
      .en  (w_load & w_trap),
      .d   (1'b1),
      .q   (r_ofl_exc)
   );

   assign mem_ofl_exc = r_ofl_exc;
`else
   logic w_unused_ofl;

   assign w_unused_ofl = ex_alu_ofl ^ ex_arith;
   assign w_trap       = 1'b0;
   assign mem_ofl_exc  = 1'b0;
`endif

   // An overflow trap halts exactly like a HALT instruction.
   assign w_halt_go = ex_valid & (ex_halt | w_trap);

   dff #(.W(1)) u_state (
      .clk (clk),
      .rst (rst),
      .d   (w_state_nxt),
      .q   (r_state)
   );

   always_comb begin
      w_state_nxt = r_state;
      if ((r_state == ST_RUN) && w_load && w_halt_go) begin
         w_state_nxt = ST_HALTED;
      end
   end

   // A live redirect means the incoming EX instruction is on the wrong path.
   always_comb begin
      w_halted = (r_state == ST_HALTED);
      w_load   = 1'b0;
      w_bubble = 1'b0;
      if (w_halted) begin
         w_bubble = 1'b1;
      end else if (stall) begin
         w_bubble = 1'b0;
      end else if (flush || r_ctrl[0]) begin
         w_bubble = 1'b1;
      end else begin
         w_load = 1'b1;
      end
   end

   assign w_ctrl_d = w_load ? {ex_valid,
                               ex_reg_wr & ~w_trap,
                               ex_mem_rd,
                               ex_mem_wr,
                               w_taken & ~w_halt_go} : 5'b0;

   dff_en #(.W(5)) u_ctrl (
      .clk (clk),
      .rst (rst),
      .en  (w_load | w_bubble),
      .d   (w_ctrl_d),
      .q   (r_ctrl)
   );

   assign w_data_d = {ex_alu_out, ex_pc_inc, ex_rd, ex_st_data, ex_br_target};

   dff_en #(.W(C_DATA_W)) u_data (
      .clk (clk),
      .rst (rst),
      .en  (w_load),
      .d   (w_data_d),
      .q   (r_data)
   );

   assign {mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr, mem_redirect} = r_ctrl;
   assign {mem_alu_out, mem_pc_inc, mem_rd, mem_st_data, mem_redirect_pc} = r_data;
   assign mem_halted = w_halted;
endmodule

`default_nettype wire

// File: tb/tb_ex_mem_latch.sv
// ============================================================================
// Module   : tb_ex_mem_latch
// Brief    : Self-checking bench for ex_mem_latch against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mem_latch;
   localparam int W = 16;
   localparam int R = 3;
`ifdef EX_MEM_OFL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         ex_valid, ex_alu_z, ex_alu_n, ex_alu_ofl;
   logic [W-1:0] ex_alu_out, ex_br_target, ex_pc_inc, ex_st_data;
   logic [2:0]   ex_br_type;
   logic [R-1:0] ex_rd;
   logic         ex_reg_wr, ex_mem_rd, ex_mem_wr, ex_halt, ex_arith;
   logic         stall, flush;
   logic         mem_valid, mem_reg_wr, mem_mem_rd, mem_mem_wr;
   logic [W-1:0] mem_alu_out, mem_pc_inc, mem_st_data, mem_redirect_pc;
   logic [R-1:0] mem_rd;
   logic         mem_redirect, mem_halted, mem_ofl_exc;

   int checks = 0;
   int errors = 0;

   ex_mem_latch dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
      .ex_alu_z(ex_alu_z), .ex_alu_n(ex_alu_n), .ex_alu_ofl(ex_alu_ofl),
      .ex_br_type(ex_br_type), .ex_br_target(ex_br_target), .ex_pc_inc(ex_pc_inc),
      .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_st_data(ex_st_data), .ex_halt(ex_halt), .ex_arith(ex_arith),
      .stall(stall), .flush(flush), .mem_valid(mem_valid), .mem_alu_out(mem_alu_out),
      .mem_pc_inc(mem_pc_inc), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr),
      .mem_mem_rd(mem_mem_rd), .mem_mem_wr(mem_mem_wr), .mem_st_data(mem_st_data),
      .mem_redirect(mem_redirect), .mem_redirect_pc(mem_redirect_pc),
      .mem_halted(mem_halted), .mem_ofl_exc(mem_ofl_exc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] alu;
      logic [W-1:0] pc_inc;
      logic [R-1:0] rd;
      logic         reg_wr;
      logic         mem_rd;
      logic         mem_wr;
      logic [W-1:0] st;
      logic         redirect;
      logic [W-1:0] rpc;
      logic         halted;
      logic         ofl;
   } obs_t;

   obs_t m;

   function automatic logic ref_taken(input int bt, input logic z, input logic n);
      case (bt)
         1: return z;
         2: return !z;
         3: return n;
         4: return !n;
         5: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic obs_t observed();
      obs_t o;
      o = '{mem_valid, mem_alu_out, mem_pc_inc, mem_rd, mem_reg_wr, mem_mem_rd,
            mem_mem_wr, mem_st_data, mem_redirect, mem_redirect_pc, mem_halted, mem_ofl_exc};
      return o;
   endfunction

   // One clock: the model applies the stage rules to the inputs seen at the edge.
   task automatic cycle();
      logic trap, hg;
      @(posedge clk);
      if (rst) begin
         m = '0;
      end else if (m.halted || (!stall && (flush || m.redirect))) begin
         m.valid = 0; m.reg_wr = 0; m.mem_rd = 0; m.mem_wr = 0; m.redirect = 0;
      end else if (!stall) begin
         trap       = TRAP && ex_valid && ex_arith && ex_alu_ofl;
         hg         = ex_valid && (ex_halt || trap);
         m.valid    = ex_valid;
         m.alu      = ex_alu_out;
         m.pc_inc   = ex_pc_inc;
         m.rd       = ex_rd;
         m.reg_wr   = ex_reg_wr && !trap;
         m.mem_rd   = ex_mem_rd;
         m.mem_wr   = ex_mem_wr;
         m.st       = ex_st_data;
         m.redirect = ex_valid && ref_taken(int'(ex_br_type), ex_alu_z, ex_alu_n) && !hg;
         m.rpc      = ex_br_target;
         m.halted   = hg;
         m.ofl      = m.ofl | trap;
      end
      #1;
   endtask

   task automatic set_nop();
      rst = 0; stall = 0; flush = 0;
      ex_valid = 0; ex_alu_out = '0; ex_alu_z = 0; ex_alu_n = 0; ex_alu_ofl = 0;
      ex_br_type = 3'd0; ex_br_target = '0; ex_pc_inc = '0; ex_rd = '0;
      ex_reg_wr = 0; ex_mem_rd = 0; ex_mem_wr = 0; ex_st_data = '0;
      ex_halt = 0; ex_arith = 0;
   endtask

   task automatic rand_inputs();
      ex_valid     = 1'($urandom);
      ex_alu_out   = 16'($urandom);
      ex_alu_z     = 1'($urandom);
      ex_alu_n     = 1'($urandom);
      ex_alu_ofl   = 1'($urandom);
      ex_br_type   = 3'($urandom_range(0, 7));
      ex_br_target = 16'($urandom);
      ex_pc_inc    = 16'($urandom);
      ex_rd        = 3'($urandom);
      ex_reg_wr    = 1'($urandom);
      ex_mem_rd    = 1'($urandom);
      ex_mem_wr    = 1'($urandom);
      ex_st_data   = 16'($urandom);
      ex_halt      = 0;
      ex_arith     = 0;
      stall        = ($urandom_range(0, 3) == 0);
      flush        = ($urandom_range(0, 4) == 0);
   endtask

   task automatic test_reset();
      rand_inputs();
      rst = 1;
      for (int i = 0; i < 2; i++) begin
         cycle();
         checks++;
         if (observed() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
         end
      end
      set_nop();
      ex_valid = 1; ex_alu_out = 16'h1234;
      cycle();
      checks++;
      if (mem_alu_out !== 16'h1234 || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL first_load: got alu=%h valid=%b expected alu=1234 valid=1",
                  mem_alu_out, mem_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         rand_inputs();
         cycle();
         checks++;
         if (observed() !== m) begin
            errors++;
            $display("FAIL random_%0d: got %h expected %h", i, observed(), m);
         end
      end
   endtask

   task automatic test_branch();
      set_nop(); cycle(); cycle();
      ex_valid = 1; ex_br_type = 3'd1; ex_alu_z = 1; ex_br_target = 16'h0040;
      cycle();
      checks++;
      if (mem_redirect !== 1'b1 || mem_redirect_pc !== 16'h0040) begin
         errors++;
         $display("FAIL beqz_taken: got redir=%b pc=%h expected 1 0040", mem_redirect, mem_redirect_pc);
      end
      set_nop(); ex_valid = 1; ex_reg_wr = 1; ex_alu_out = 16'h5555;
      cycle();
      checks++;
      if (mem_valid !== 1'b0 || mem_redirect !== 1'b0 || mem_reg_wr !== 1'b0) begin
         errors++;
         $display("FAIL self_squash: got valid=%b redir=%b wr=%b expected 0 0 0",
                  mem_valid, mem_redirect, mem_reg_wr);
      end
      set_nop(); ex_valid = 1; ex_br_type = 3'd2; ex_alu_z = 1; ex_br_target = 16'h0080;
      cycle();
      checks++;
      if (mem_redirect !== 1'b0 || mem_valid !== 1'b1) begin
         errors++;
         $display("FAIL bnez_not_taken: got redir=%b valid=%b expected 0 1", mem_redirect, mem_valid);
      end
   endtask

   task automatic test_stall_flush();
      set_nop(); cycle();
      ex_valid = 1; ex_br_type = 3'd5; ex_br_target = 16'h0abc; ex_alu_out = 16'h1111;
      cycle();
      for (int i = 0; i < 3; i++) begin
         rand_inputs();
         stall = 1;
         cycle();
         checks++;
         if (mem_redirect !== 1'b1 || mem_redirect_pc !== 16'h0abc ||
             mem_alu_out !== 16'h1111 || mem_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold_%0d: got redir=%b pc=%h alu=%h valid=%b expected 1 0abc 1111 1",
                     i, mem_redirect, mem_redirect_pc, mem_alu_out, mem_valid);
         end
      end
      set_nop(); cycle();
      ex_valid = 1; ex_reg_wr = 1; flush = 1;
      cycle();
      checks++;
      if (mem_valid !== 1'b0 || mem_reg_wr !== 1'b0 || observed() !== m) begin
         errors++;
         $display("FAIL flush_bubble: got valid=%b wr=%b expected 0 0", mem_valid, mem_reg_wr);
      end
   endtask

   task automatic test_back_to_back();
      set_nop(); cycle(); cycle();
      ex_valid = 1; ex_br_type = 3'd5; ex_br_target = 16'h0100;
      cycle();
      checks++;
      if (mem_redirect !== 1'b1 || mem_redirect_pc !== 16'h0100) begin
         errors++;
         $display("FAIL jump1: got redir=%b pc=%h expected 1 0100", mem_redirect, mem_redirect_pc);
      end
      ex_br_target = 16'h0200;
      cycle();
      checks++;
      if (mem_redirect !== 1'b0 || mem_valid !== 1'b0 || mem_redirect_pc !== 16'h0100) begin
         errors++;
         $display("FAIL jump2_squashed: got redir=%b valid=%b pc=%h expected 0 0 0100",
                  mem_redirect, mem_valid, mem_redirect_pc);
      end
   endtask

   task automatic test_halt();
      set_nop(); cycle();
      ex_valid = 1; ex_halt = 1; ex_br_type = 3'd5; ex_br_target = 16'h0300; ex_alu_out = 16'h7777;
      cycle();
      checks++;
      if (mem_halted !== 1'b1 || mem_valid !== 1'b1 || mem_redirect !== 1'b0 || mem_alu_out !== 16'h7777) begin
         errors++;
         $display("FAIL halt_latch: got halted=%b valid=%b redir=%b alu=%h expected 1 1 0 7777",
                  mem_halted, mem_valid, mem_redirect, mem_alu_out);
      end
      for (int i = 0; i < 5; i++) begin
         rand_inputs();
         ex_valid = 1;
         cycle();
         checks++;
         if (mem_valid !== 1'b0 || mem_halted !== 1'b1 || mem_redirect !== 1'b0) begin
            errors++;
            $display("FAIL halted_bubble_%0d: got valid=%b halted=%b redir=%b expected 0 1 0",
                     i, mem_valid, mem_halted, mem_redirect);
         end
      end
      rst = 1; stall = 1;
      cycle();
      checks++;
      if (observed() !== obs_t'(0)) begin
         errors++;
         $display("FAIL halt_reset: got %h expected 0", observed());
      end
      set_nop();
   endtask

   task automatic test_ofl();
      set_nop(); cycle();
      ex_valid = 1; ex_arith = 1; ex_alu_ofl = 1; ex_reg_wr = 1; ex_alu_out = 16'h8000;
      cycle();
      checks++;
      if (mem_reg_wr !== !TRAP || mem_ofl_exc !== TRAP || mem_halted !== TRAP) begin
         errors++;
         $display("FAIL ofl_add: got wr=%b exc=%b halted=%b expected %b %b %b",
                  mem_reg_wr, mem_ofl_exc, mem_halted, !TRAP, TRAP, TRAP);
      end
      set_nop(); cycle();
      checks++;
      if (mem_ofl_exc !== TRAP || observed() !== m) begin
         errors++;
         $display("FAIL ofl_sticky: got exc=%b expected %b", mem_ofl_exc, TRAP);
      end
      rst = 1; cycle(); set_nop();
   endtask

   initial begin
      m = '0;
      set_nop();
      rst = 1;
      test_reset();
      test_random();
      test_branch();
      test_stall_flush();
      test_back_to_back();
      test_halt();
      test_ofl();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
